lsu_mem_access: RTL
===================

Name: lsu_mem_access

Overview:
- Load/store unit that sits directly upstream of the DPI-backed data RAM.
- Accepts one load or store request from the execute stage and drives the RAM's valid/writeEnable/writeAddr/writeData/writeMask/readAddr for exactly one cycle.
- Captures the registered RAM read data, performs byte/halfword extraction with sign or zero extension, and returns a result to writeback over a valid/ready handshake.
- Holds one outstanding request at a time; it does not pipeline.

Parameters:
- ADDR_WIDTH, 32, request and RAM address width.
- DATA_WIDTH, 32, data width; only 32 is supported, and other values are an elaboration error.

Ports:
- clock  input  1  single clock; everything updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- reqValid  input  1  request present.
- reqReady  output  1  high only in IDLE.
- reqWrite  input  1  1 = store, 0 = load.
- reqFunct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- reqAddr  input  ADDR_WIDTH  byte address.
- reqWdata  input  32  store data, right-aligned.
- memValid  output  1  RAM access strobe.
- memWriteEnable  output  1  RAM write.
- memWriteAddr  output  ADDR_WIDTH  word-aligned address (addr & ~3).
- memWriteData  output  32  lane-shifted store data.
- memWriteMask  output  4  byte lanes.
- memReadAddr  output  ADDR_WIDTH  word-aligned address.
- memReadData  input  32  RAM read data, valid only in the cycle after memValid.
- respValid  output  1  result available.
- respReady  input  1  writeback accepts.
- respData  output  32  load result; 0 for stores.
- respErr  output  1  misaligned access or illegal funct3.

Behaviour:
- Reset value of every output is 0, except reqReady, which is 1 while reset is deasserted in IDLE. State resets to IDLE.
- States:
  - IDLE: on reqValid & reqReady at an edge, latch reqWrite, reqFunct3, reqAddr and reqWdata. If the request is illegal, go to RESP with err=1 and data=0; otherwise go to ACCESS.
  - ACCESS: lasts exactly one cycle. memValid=1, memWriteEnable=latched write, address and mask driven, then go to CAPTURE.
  - CAPTURE: lasts one cycle with memValid=0. At the edge, register the extracted memReadData into respData (stores register 0), then go to RESP.
  - RESP: respValid=1, with respData and respErr held stable. On respReady go to IDLE.
- Latency from the accept edge: respValid rises 3 cycles later. With respReady tied high, throughput is one request per 4 cycles.
- A request is illegal when:
  - reqFunct3 is 011, 110 or 111;
  - reqFunct3 is 11x for stores or 1xx for stores (only 000/001/010 are valid stores);
  - a halfword access has addr[0]=1;
  - a word access has addr[1:0]≠0.
  Illegal requests never assert memValid.
- Store mask, with o=addr[1:0]:
  - B: 0001<<o.
  - H: 0011<<o.
  - W: 1111.
- Store data: reqWdata shifted left by 8·o. For B and H, bits outside the active lanes are 0.
- Load extract: memReadData shifted right by 8·o, then:
  - B: sign-extend bit 7.
  - BU: zero-extend from 8 bits.
  - H: sign-extend bit 15.
  - HU: zero-extend from 16 bits.
  - W: unchanged.
- Outside ACCESS, memValid, memWriteEnable and memWriteMask are 0. Address and data outputs are don't-care but are driven from the latched values.
- Backpressure: in RESP with respReady=0, stay in RESP with all resp outputs stable. reqReady stays 0.
- Reset mid-operation: memValid drops asynchronously, state returns to IDLE, and the outstanding request is discarded. A write already strobed in ACCESS is not undone.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, ACCESS, CAPTURE, RESP};
  - the widths.
- One combinational sub-module, lsu_align, holds:
  - store mask and data shifting;
  - the legality check;
  - load extraction and extension.
- lsu_mem_access contains the FSM and the request/response registers.

Test Plan:
1. LW 0x80000004, RAM word 0xDEADBEEF -> memValid high exactly 1 cycle with readAddr 0x80000004; respData 0xDEADBEEF and respErr 0 three cycles after accept.
2. LB 0x80000003, then LHU 0x80000002, RAM word 0x80FF1234 -> respData 0xFFFFFF80, then 0x000080FF.
3. SB 0x80000001, wdata 0x000000AB -> memWriteEnable=1, memWriteMask 0010, memWriteData 0x0000AB00, writeAddr 0x80000000; respData 0.
4. LW 0x80000002, then SH 0x80000001, then funct3=011 -> each gives respErr=1 and respData 0 with memValid never high; respValid rises one cycle after accept.
5. LW completes with respReady held low for 5 cycles -> respValid and respData stable throughout, reqReady 0; IDLE one cycle after respReady rises.
6. Assert reset during ACCESS of a SW -> memValid falls immediately with no clock edge, all outputs 0 and reqReady 1 after release; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings,
// FSM states and datapath widths.
package lsu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: legality check on the incoming
// request, store mask/data shifting and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        chk_write_i,
    input  logic [2:0]  chk_f3_i,
    input  logic [1:0]  chk_off_i,
    output logic        legal_o,
    input  logic [2:0]  f3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [31:0] rshift;

    assign sh     = {off_i, 3'b000};
    assign rshift = rdata_i >> sh;

    always_comb begin
        legal_o = 1'b0;
        unique case (chk_f3_i)
            F3_B:    legal_o = 1'b1;
            F3_H:    legal_o = !chk_off_i[0];
            F3_W:    legal_o = (chk_off_i == 2'b00);
            F3_BU:   legal_o = !chk_write_i;
            F3_HU:   legal_o = !chk_write_i && !chk_off_i[0];
            default: legal_o = 1'b0;
        endcase
    end

    always_comb begin
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        unique case (f3_i)
            F3_B: begin
                mask_o  = 4'b0001 << off_i;
                wdata_o = {24'h0, wdata_i[7:0]} << sh;
            end
            F3_H: begin
                mask_o  = 4'b0011 << off_i;
                wdata_o = {16'h0, wdata_i[15:0]} << sh;
            end
            default: begin
                mask_o  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        rdata_o = rshift;
        unique case (f3_i)
            F3_B:    rdata_o = {{24{rshift[7]}}, rshift[7:0]};
            F3_BU:   rdata_o = {24'h0, rshift[7:0]};
            F3_H:    rdata_o = {{16{rshift[15]}}, rshift[15:0]};
            F3_HU:   rdata_o = {16'h0, rshift[15:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Non-pipelined load/store unit: one request at a time, a single-cycle
// RAM strobe, then a registered and extended result to writeback.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [2:0]            reqFunct3,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqWdata,
    output logic                  memValid,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memWriteAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic [3:0]            memWriteMask,
    output logic [ADDR_WIDTH-1:0] memReadAddr,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  respErr
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("lsu_mem_access: DATA_WIDTH must be 32");
    end

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic                  err_q, err_d;

    logic        legal;
    logic [3:0]  mask;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    lsu_align u_align (
        .chk_write_i (reqWrite),
        .chk_f3_i    (reqFunct3),
        .chk_off_i   (reqAddr[1:0]),
        .legal_o     (legal),
        .f3_i        (f3_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_i     (memReadData),
        .mask_o      (mask),
        .wdata_o     (st_data),
        .rdata_o     (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (reqValid && reqReady) begin
                    write_d = reqWrite;
                    f3_d    = reqFunct3;
                    addr_d  = reqAddr;
                    wdata_d = reqWdata;
                    // Illegal requests skip the RAM entirely.
                    if (!legal) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: begin
                data_d  = write_q ? 32'h0 : ld_data;
                state_d = RESP;
            end
            RESP: begin
                if (respReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reqReady       = (state_q == IDLE) && !reset;
    assign memValid       = (state_q == ACCESS);
    assign memWriteEnable = memValid && write_q;
    assign memWriteMask   = memValid ? mask : 4'b0000;
    assign memWriteAddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign memReadAddr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign memWriteData   = st_data;
    assign respValid      = (state_q == RESP);
    assign respData       = data_q;
    assign respErr        = err_q;

endmodule
